// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives a 16-bit synchronous data memory, splits
// word accesses into two halfword beats and registers results into MEM/WB.
module mem_access_stage #(
    parameter int ADDR_W    = 32,
    parameter int HI_OFFSET = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_signed_i,
    input  logic              mem_to_reg_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [15:0]       dmem_wdata_o,
    output logic [1:0]        dmem_be_o,
    output logic              dmem_we_o,
    output logic              dmem_re_o,
    input  logic [15:0]       dmem_rdata_i,
    output logic              stall_o,
    output logic              align_err_o,
    output logic              wb_valid_o,
    output logic              wb_mem_to_reg_o,
    output logic [31:0]       wb_calc_o,
    output logic [31:0]       wb_load_data_o
);

    typedef enum logic {IDLE, HI} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t            state_reg, state_next;
    logic              wb_valid_reg, wb_valid_next;
    logic              wb_m2r_reg, wb_m2r_next;
    logic [31:0]       wb_calc_reg;
    logic [15:0]       lo_reg;
    logic [1:0]        size_reg;
    logic              lane_reg;
    logic              sign_reg;

    logic              is_access;
    logic              misaligned;
    logic              issue;
    logic              wb_load;
    logic              lo_capture;
    logic              align_err;
    logic              stall;
    logic [ADDR_W-1:0] addr_base;
    logic [15:0]       byte_rep_wdata;
    logic [7:0]        byte_sel;

    assign is_access = mem_read_i | mem_write_i;
    assign addr_base = {alu_result_i[ADDR_W-1:1], 1'b0};

    // A byte store is replicated onto both lanes; the byte enables pick the lane.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign byte_rep_wdata[gi*8 +: 8] = store_data_i[7:0];
    end

    always_comb begin
        misaligned = 1'b0;
        case (mem_size_i)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = alu_result_i[0];
            SIZE_WORD: misaligned = |alu_result_i[1:0];
            default:   misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        issue         = 1'b0;
        wb_load       = 1'b0;
        wb_valid_next = 1'b0;
        wb_m2r_next   = 1'b0;
        lo_capture    = 1'b0;
        align_err     = 1'b0;
        stall         = 1'b0;
        dmem_addr_o   = addr_base;
        dmem_wdata_o  = (mem_size_i == SIZE_BYTE) ? byte_rep_wdata : store_data_i[15:0];
        dmem_be_o     = 2'b11;
        if (mem_size_i == SIZE_BYTE) begin
            dmem_be_o = alu_result_i[0] ? 2'b10 : 2'b01;
        end

        case (state_reg)
            IDLE: begin
                if (ex_valid_i) begin
                    if (is_access && misaligned) begin
                        align_err = 1'b1;
                        wb_load   = 1'b1;
                    end else if (is_access) begin
                        issue = 1'b1;
                        if (mem_size_i == SIZE_WORD) begin
                            stall      = 1'b1;
                            state_next = HI;
                        end else begin
                            wb_load     = 1'b1;
                            wb_m2r_next = mem_to_reg_i;
                        end
                    end else begin
                        wb_load     = 1'b1;
                        wb_m2r_next = mem_to_reg_i;
                    end
                end
            end
            HI: begin
                issue        = 1'b1;
                wb_load      = 1'b1;
                wb_m2r_next  = mem_to_reg_i;
                dmem_addr_o  = addr_base + ADDR_W'(HI_OFFSET);
                dmem_wdata_o = store_data_i[31:16];
                // Read data arriving now belongs to the low-half read issued in IDLE.
                lo_capture   = mem_read_i & ~mem_write_i;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        wb_valid_next = wb_load;
    end

    // Strobes are masked by reset so an aborted word access issues nothing.
    assign dmem_we_o   = rst_ni & issue & mem_write_i;
    assign dmem_re_o   = rst_ni & issue & mem_read_i & ~mem_write_i;
    assign stall_o     = rst_ni & stall;
    assign align_err_o = rst_ni & align_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            wb_valid_reg <= 1'b0;
            wb_m2r_reg   <= 1'b0;
            wb_calc_reg  <= 32'd0;
            lo_reg       <= 16'd0;
            size_reg     <= 2'b00;
            lane_reg     <= 1'b0;
            sign_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= wb_valid_next;
            wb_m2r_reg   <= wb_m2r_next;
            if (wb_load) begin
                wb_calc_reg <= 32'(alu_result_i);
                size_reg    <= mem_size_i;
                lane_reg    <= alu_result_i[0];
                sign_reg    <= mem_signed_i;
            end
            if (lo_capture) begin
                lo_reg <= dmem_rdata_i;
            end
        end
    end

    assign byte_sel = lane_reg ? dmem_rdata_i[15:8] : dmem_rdata_i[7:0];

    always_comb begin
        wb_load_data_o = 32'd0;
        if (wb_valid_reg && wb_m2r_reg) begin
            case (size_reg)
                SIZE_BYTE: wb_load_data_o = {{24{sign_reg & byte_sel[7]}}, byte_sel};
                SIZE_HALF: wb_load_data_o = {{16{sign_reg & dmem_rdata_i[15]}}, dmem_rdata_i};
                SIZE_WORD: wb_load_data_o = {dmem_rdata_i, lo_reg};
                default:   wb_load_data_o = 32'd0;
            endcase
        end
    end

    assign wb_valid_o      = wb_valid_reg;
    assign wb_mem_to_reg_o = wb_m2r_reg;
    assign wb_calc_o       = wb_calc_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small synchronous halfword memory model.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        mem_to_reg;
    logic [31:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_be;
    logic        dmem_we;
    logic        dmem_re;
    logic [15:0] dmem_rdata;
    logic        stall;
    logic        align_err;
    logic        wb_valid;
    logic        wb_mem_to_reg;
    logic [31:0] wb_calc;
    logic [31:0] wb_load_data;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] mem [0:511];
    logic        wrote_102 = 1'b0;

    mem_access_stage #(.ADDR_W(32), .HI_OFFSET(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ex_valid_i     (ex_valid),
        .alu_result_i   (alu_result),
        .store_data_i   (store_data),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_size_i     (mem_size),
        .mem_signed_i   (mem_signed),
        .mem_to_reg_i   (mem_to_reg),
        .dmem_addr_o    (dmem_addr),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_be_o      (dmem_be),
        .dmem_we_o      (dmem_we),
        .dmem_re_o      (dmem_re),
        .dmem_rdata_i   (dmem_rdata),
        .stall_o        (stall),
        .align_err_o    (align_err),
        .wb_valid_o     (wb_valid),
        .wb_mem_to_reg_o(wb_mem_to_reg),
        .wb_calc_o      (wb_calc),
        .wb_load_data_o (wb_load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_re) dmem_rdata <= mem[dmem_addr[9:1]];
        if (dmem_we) begin
            if (dmem_be[0]) mem[dmem_addr[9:1]][7:0]  <= dmem_wdata[7:0];
            if (dmem_be[1]) mem[dmem_addr[9:1]][15:8] <= dmem_wdata[15:8];
            if (dmem_addr == 32'h102) wrote_102 <= 1'b1;
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                         input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic m2r);
        ex_valid = v; alu_result = a; store_data = sd; mem_read = rd;
        mem_write = wr; mem_size = sz; mem_signed = sg; mem_to_reg = m2r;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        compared++; if (wb_valid !== 1'b0) begin mismatched++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
        compared++; if ({dmem_we, dmem_re, stall, align_err} !== 4'b0) begin mismatched++; $display("FAIL reset_strobes got %b want 0000", {dmem_we, dmem_re, stall, align_err}); end
        compared++; if (wb_load_data !== 32'h0 || wb_calc !== 32'h0) begin mismatched++; $display("FAIL reset_wb_data got %h/%h want 0/0", wb_load_data, wb_calc); end
        @(negedge clk); rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_reset_mid_hi;
        drive(1, 32'h100, 32'h1111_2222, 0, 1, 2'b10, 0, 0); #1;
        compared++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h100 || dmem_wdata !== 16'h2222) begin mismatched++; $display("FAIL rst_hi_lo got we=%0b addr=%h wd=%h want 1/100/2222", dmem_we, dmem_addr, dmem_wdata); end
        @(negedge clk); #1;
        compared++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h102) begin mismatched++; $display("FAIL rst_hi_issue got we=%0b addr=%h want 1/102", dmem_we, dmem_addr); end
        rst_n = 1'b0; #1;
        compared++; if (dmem_we !== 1'b0) begin mismatched++; $display("FAIL rst_hi_we_drop got %0b want 0", dmem_we); end
        compared++; if ({stall, wb_valid, wb_load_data} !== 34'h0) begin mismatched++; $display("FAIL rst_hi_outputs got stall=%0b wbv=%0b ld=%h want 0", stall, wb_valid, wb_load_data); end
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        compared++; if (wrote_102 !== 1'b0) begin mismatched++; $display("FAIL rst_hi_no_write got %0b want 0", wrote_102); end
        compared++; if ({dmem_we, dmem_re, wb_valid} !== 3'b0) begin mismatched++; $display("FAIL rst_hi_quiet got %b want 000", {dmem_we, dmem_re, wb_valid}); end
        $display("reset_mid_hi: done");
    endtask

    task automatic test_word_store;
        @(negedge clk);
        drive(1, 32'h40, 32'hDEAD_BEEF, 0, 1, 2'b10, 0, 0); #1;
        compared++; if (dmem_addr !== 32'h40 || dmem_wdata !== 16'hBEEF || dmem_we !== 1'b1 || stall !== 1'b1 || dmem_be !== 2'b11) begin mismatched++; $display("FAIL wst_c0 got addr=%h wd=%h we=%0b st=%0b be=%b want 40/beef/1/1/11", dmem_addr, dmem_wdata, dmem_we, stall, dmem_be); end
        @(negedge clk); #1;
        compared++; if (dmem_addr !== 32'h42 || dmem_wdata !== 16'hDEAD || dmem_we !== 1'b1 || stall !== 1'b0) begin mismatched++; $display("FAIL wst_c1 got addr=%h wd=%h we=%0b st=%0b want 42/dead/1/0", dmem_addr, dmem_wdata, dmem_we, stall); end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0); #1;
        compared++; if (wb_valid !== 1'b1 || wb_calc !== 32'h40) begin mismatched++; $display("FAIL wst_wb got v=%0b calc=%h want 1/40", wb_valid, wb_calc); end
        $display("word_store: 0xDEADBEEF -> 0x40");
    endtask

    task automatic test_word_load;
        @(negedge clk);
        drive(1, 32'h40, 32'h0, 1, 0, 2'b10, 0, 1); #1;
        compared++; if (dmem_re !== 1'b1 || stall !== 1'b1 || dmem_addr !== 32'h40) begin mismatched++; $display("FAIL wld_c0 got re=%0b st=%0b addr=%h want 1/1/40", dmem_re, stall, dmem_addr); end
        @(negedge clk); #1;
        compared++; if (dmem_re !== 1'b1 || stall !== 1'b0 || dmem_addr !== 32'h42) begin mismatched++; $display("FAIL wld_c1 got re=%0b st=%0b addr=%h want 1/0/42", dmem_re, stall, dmem_addr); end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0); #1;
        compared++; if (wb_valid !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_load_data !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL wld_data got v=%0b m2r=%0b ld=%h want 1/1/deadbeef", wb_valid, wb_mem_to_reg, wb_load_data); end
        $display("word_load: 0x40 -> %h", wb_load_data);
    endtask

    task automatic test_byte_loads;
        @(negedge clk);
        drive(1, 32'h40, 32'h0000_80FF, 0, 1, 2'b01, 0, 0); #1;
        compared++; if (dmem_we !== 1'b1 || dmem_be !== 2'b11 || stall !== 1'b0 || dmem_wdata !== 16'h80FF) begin mismatched++; $display("FAIL hst got we=%0b be=%b st=%0b wd=%h want 1/11/0/80ff", dmem_we, dmem_be, stall, dmem_wdata); end
        @(negedge clk);
        drive(1, 32'h41, 32'h0, 1, 0, 2'b00, 1, 1); #1;
        compared++; if (dmem_re !== 1'b1 || dmem_be !== 2'b10 || dmem_addr !== 32'h40 || stall !== 1'b0) begin mismatched++; $display("FAIL lbs_issue got re=%0b be=%b addr=%h st=%0b want 1/10/40/0", dmem_re, dmem_be, dmem_addr, stall); end
        @(negedge clk);
        compared++; if (wb_load_data !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL lbs_data got %h want ffffff80", wb_load_data); end
        drive(1, 32'h41, 32'h0, 1, 0, 2'b00, 0, 1);
        @(negedge clk);
        compared++; if (wb_valid !== 1'b1 || wb_load_data !== 32'h0000_0080) begin mismatched++; $display("FAIL lbu_data got v=%0b ld=%h want 1/00000080", wb_valid, wb_load_data); end
        drive(1, 32'h40, 32'h0, 1, 0, 2'b01, 1, 1);
        @(negedge clk);
        compared++; if (wb_load_data !== 32'hFFFF_80FF) begin mismatched++; $display("FAIL lhs_data got %h want ffff80ff", wb_load_data); end
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0);
        $display("byte_loads: signed/unsigned from 0x41, half from 0x40");
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        drive(1, 32'h43, 32'h0, 1, 0, 2'b01, 0, 1); #1;
        compared++; if (align_err !== 1'b1 || dmem_re !== 1'b0 || dmem_we !== 1'b0) begin mismatched++; $display("FAIL mis_pulse got err=%0b re=%0b we=%0b want 1/0/0", align_err, dmem_re, dmem_we); end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0); #1;
        compared++; if (wb_valid !== 1'b1 || wb_mem_to_reg !== 1'b0 || wb_load_data !== 32'h0 || align_err !== 1'b0) begin mismatched++; $display("FAIL mis_wb got v=%0b m2r=%0b ld=%h err=%0b want 1/0/0/0", wb_valid, wb_mem_to_reg, wb_load_data, align_err); end
        @(negedge clk);
        drive(1, 32'h8, 32'h0, 0, 1, 2'b11, 0, 0); #1;
        compared++; if (align_err !== 1'b1 || dmem_we !== 1'b0) begin mismatched++; $display("FAIL mis_size11 got err=%0b we=%0b want 1/0", align_err, dmem_we); end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0);
        $display("misaligned: half @0x43 and size 11 flagged");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(1, 32'h1234, 32'h0, 0, 0, 2'b10, 0, 0); #1;
        compared++; if ({dmem_we, dmem_re, stall, align_err} !== 4'b0) begin mismatched++; $display("FAIL alu_nostrobe got %b want 0000", {dmem_we, dmem_re, stall, align_err}); end
        @(negedge clk);
        compared++; if (wb_valid !== 1'b1 || wb_calc !== 32'h1234 || wb_mem_to_reg !== 1'b0) begin mismatched++; $display("FAIL alu_wb got v=%0b calc=%h m2r=%0b want 1/1234/0", wb_valid, wb_calc, wb_mem_to_reg); end
        drive(1, 32'h20, 32'h0000_5678, 0, 1, 2'b01, 0, 0); #1;
        compared++; if (dmem_we !== 1'b1 || dmem_be !== 2'b11 || stall !== 1'b0 || dmem_addr !== 32'h20 || dmem_wdata !== 16'h5678) begin mismatched++; $display("FAIL b2b_store got we=%0b be=%b st=%0b addr=%h wd=%h want 1/11/0/20/5678", dmem_we, dmem_be, stall, dmem_addr, dmem_wdata); end
        @(negedge clk);
        drive(1, 32'h20, 32'h0, 1, 0, 2'b01, 0, 1); #1;
        compared++; if (dmem_we !== 1'b0 || dmem_re !== 1'b1) begin mismatched++; $display("FAIL b2b_single_write got we=%0b re=%0b want 0/1", dmem_we, dmem_re); end
        @(negedge clk);
        drive(1, 32'h100, 32'h0, 1, 0, 2'b01, 0, 1);
        compared++; if (wb_load_data !== 32'h0000_5678) begin mismatched++; $display("FAIL b2b_readback got %h want 00005678", wb_load_data); end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0);
        compared++; if (wb_load_data !== 32'h0000_2222) begin mismatched++; $display("FAIL rst_lo_kept got %h want 00002222", wb_load_data); end
        @(negedge clk);
        compared++; if (wb_valid !== 1'b0) begin mismatched++; $display("FAIL idle_wb got %0b want 0", wb_valid); end
        $display("back_to_back: alu 0x1234 then half store 0x5678 @0x20");
    endtask

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        dmem_rdata = 16'h0;
        drive(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0);
        test_reset;
        test_reset_mid_hi;
        test_word_store;
        test_word_load;
        test_byte_loads;
        test_misaligned;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage between execute and write-back/fetch.
- Drives a 16-bit synchronous data memory and splits 32-bit loads/stores into two halfword accesses, stalling upstream for one cycle.
- Registers results into a MEM/WB register. Presents assembled, extended load data to write-back one cycle after the last read is issued.

Parameters:
- ADDR_W, 32, width of byte address / ALU result.
- HI_OFFSET, 2, byte offset of the upper halfword in a word access.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  execute presents a valid instruction.
- alu_result_i  in  ADDR_W  effective address, or calculation result.
- store_data_i  in  32  store data.
- mem_read_i  in  1  load.
- mem_write_i  in  1  store.
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
- mem_signed_i  in  1  sign-extend byte/half loads.
- mem_to_reg_i  in  1  write-back selects load data.
- dmem_addr_o  out  ADDR_W  halfword-aligned memory address.
- dmem_wdata_o  out  16  write data.
- dmem_be_o  out  2  byte enables; bit0 = low byte.
- dmem_we_o  out  1  write strobe.
- dmem_re_o  out  1  read strobe.
- dmem_rdata_i  in  16  read data, valid the cycle after dmem_re_o.
- stall_o  out  1  hold execute and fetch this cycle.
- align_err_o  out  1  one-cycle pulse on a misaligned/illegal access.
- wb_valid_o  out  1  MEM/WB register valid.
- wb_mem_to_reg_o  out  1  registered mem_to_reg.
- wb_calc_o  out  32  registered alu_result (zero-extended to 32).
- wb_load_data_o  out  32  assembled, extended load data.

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All MEM/WB registers, the low-halfword register and the lane/size/sign registers clear to 0.
  - All dmem strobes are 0, stall_o=0, align_err_o=0, wb_load_data_o=0.
  - Reset mid word access aborts the second half; no further strobes are issued.
- Accept: an access starts when ex_valid_i=1 in IDLE and (mem_read_i | mem_write_i).
  - If both mem_read_i and mem_write_i are 1, the access is treated as a store.
- Alignment:
  - Half access requires addr[0]=0; word access requires addr[1:0]=00; size 11 is always illegal.
  - On violation: align_err_o=1 that cycle, no strobes, wb_valid_o=1 next cycle with wb_mem_to_reg_o=0.
- Addressing:
  - dmem_addr_o = {addr[ADDR_W-1:1],0}, driven combinationally in the issue cycle.
  - Byte access: dmem_be_o = addr[0] ? 10 : 01; store byte replicated on both lanes.
  - Half and word accesses: dmem_be_o = 11.
- State IDLE:
  - Byte or half access: single strobe, no stall; the MEM/WB register loads at the next edge.
  - Word access: issue the low half (store_data_i[15:0]), stall_o=1, next state HI.
- State HI:
  - Issue dmem_addr_o = base + HI_OFFSET; stores write store_data_i[31:16].
  - Read data is valid one cycle after the matching dmem_re_o: for a load, dmem_rdata_i in HI carries the low halfword, which is captured into lo_reg.
  - stall_o=0; the MEM/WB register loads at the edge ending HI; next state IDLE.
  - Execute holds all inputs stable while stall_o=1; the block re-samples inputs in HI.
- Load data, combinational from dmem_rdata_i in the cycle wb_valid_o=1, using registered size/lane/sign:
  - Byte: the selected lane, sign- or zero-extended.
  - Half: sign- or zero-extended.
  - Word: {dmem_rdata_i, lo_reg}.
  - wb_load_data_o=0 when wb_mem_to_reg_o=0.
- Non-memory instruction (ex_valid_i=1, no read/write): passes through to MEM/WB in one cycle with no strobes.
- ex_valid_i=0 in IDLE: wb_valid_o=0 next cycle.
- Back-to-back accesses: a new access may issue in the cycle after HI, or the cycle after a single access; there are no bubbles.

Test Plan:
- Reset asserted mid-HI of a word store at 0x100: dmem_we_o drops immediately; no write to 0x102 after release; all outputs 0.
- Word store 0xDEADBEEF to 0x40:
  - cycle0 addr 0x40, wdata 0xBEEF, we=1, stall_o=1.
  - cycle1 addr 0x42, wdata 0xDEAD, stall_o=0.
- Word load from 0x40 with memory {0x40:0xBEEF, 0x42:0xDEAD}: wb_load_data_o=0xDEADBEEF two cycles after accept; stall_o high exactly one cycle.
- Byte loads from 0x41, where the halfword at 0x40 reads 0x80FF:
  - signed: wb_load_data_o=0xFFFFFF80, be=10.
  - unsigned: 0x00000080.
- Half load from 0x43: align_err_o pulses; no dmem_re_o; wb_valid_o=1 with wb_mem_to_reg_o=0 next cycle.
- ALU op result 0x1234 followed immediately by a half store of 0x5678 to 0x20: wb_calc_o=0x1234 then a single write, be=11, no stall.
